// File: rtl/csr_file_trap_pkg.sv
// Shared CSR address map, mstatus field positions, interrupt codes and op encodings
// for the machine-mode CSR file and trap sequencer.
package csr_file_trap_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_CUSTOM0   = 12'h7C0;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    localparam logic [1:0] MPP_M = 2'b11;
    localparam logic [1:0] MPP_U = 2'b00;

    localparam logic [4:0] IRQ_M_SW    = 5'd3;
    localparam logic [4:0] IRQ_M_TIMER = 5'd7;
    localparam logic [4:0] IRQ_M_EXT   = 5'd11;

    typedef enum logic [1:0] {
        CSR_READ  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

endpackage

// File: rtl/csr_file_trap_if.sv
// CSR access bus between the execute stage (master) and the CSR file (slave).
interface csr_file_trap_if #(
    parameter int XLEN = 32
);
    logic            csr_en;
    logic            csr_w_en;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_in;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output csr_en, csr_w_en, csr_op, csr_addr, csr_in,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_en, csr_w_en, csr_op, csr_addr, csr_in,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_file_trap_counter.sv
// CNT_WIDTH-bit event counter with independently writable XLEN-wide low and high halves.
module csr_file_trap_counter #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic [XLEN-1:0]      wdata,
    output logic [CNT_WIDTH-1:0] count
);
    localparam int HI_W = CNT_WIDTH - XLEN;

    // A software write to either half suppresses that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_lo) begin
            count[XLEN-1:0] <= wdata;
        end else if (wr_hi) begin
            count[CNT_WIDTH-1:XLEN] <= wdata[HI_W-1:0];
        end else if (inc) begin
            count <= count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: rtl/csr_file_trap.sv
// Machine-mode CSR file with cycle/instret counters, interrupt pending logic,
// and atomic trap-entry / mret state updates that also produce the fetch redirect PC.
module csr_file_trap
    import csr_file_trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              CNT_WIDTH   = 64,
    parameter int              NUM_CUSTOM  = 2,
    parameter logic [XLEN-1:0] MTVEC_RST   = '0,
    parameter bit              VECTORED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    csr_file_trap_if.slave    bus,
    input  logic              trap_req,
    input  logic              trap_is_irq,
    input  logic [4:0]        trap_cause,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic [XLEN-1:0]   trap_tval,
    input  logic              mret,
    input  logic              retire,
    input  logic              irq_sw,
    input  logic              irq_timer,
    input  logic              irq_ext,
    output logic              irq_pending,
    output logic [4:0]        irq_code,
    output logic [XLEN-1:0]   redirect_pc
);
    localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(12'h888);
    localparam logic [XLEN-1:0] MISA_VAL = (XLEN'(XLEN == 64 ? 2 : 1) << (XLEN - 2)) | XLEN'(1 << 8);

    logic                 mst_mie, mst_mpie;
    logic [1:0]           mst_mpp;
    logic [XLEN-1:0]      mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0]      cust_q [NUM_CUSTOM];
    logic [2:0]           mip_q;
    logic [CNT_WIDTH-1:0] mcycle, minstret;

    logic [XLEN-1:0] mstatus_rd, mip_rd, rdata, wdata, trap_mcause, vec_base;
    logic            hit, is_write, illegal, commit;
    logic [2:0]      irq_act;

    function automatic logic [XLEN-1:0] csr_wval(input logic [1:0] op,
                                                  input logic [XLEN-1:0] old_v,
                                                  input logic [XLEN-1:0] in_v);
        case (op)
            CSR_SET:   return old_v | in_v;
            CSR_CLEAR: return old_v & ~in_v;
            default:   return in_v;
        endcase
    endfunction

    // Reserved MODE encodings collapse to direct mode, as does any write when vectoring is disabled.
    function automatic logic [XLEN-1:0] mtvec_legal(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        if (!VECTORED_EN || v[1]) r[1:0] = 2'b00;
        return r;
    endfunction

    always_comb begin
        mstatus_rd                            = '0;
        mstatus_rd[MSTATUS_MIE]               = mst_mie;
        mstatus_rd[MSTATUS_MPIE]              = mst_mpie;
        mstatus_rd[MSTATUS_MPP_LO +: 2]       = mst_mpp;
        mip_rd                                = '0;
        mip_rd[IRQ_M_SW]                      = mip_q[0];
        mip_rd[IRQ_M_TIMER]                   = mip_q[1];
        mip_rd[IRQ_M_EXT]                     = mip_q[2];
    end

    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        case (bus.csr_addr)
            CSR_MSTATUS:               rdata = mstatus_rd;
            CSR_MISA:                  rdata = MISA_VAL;
            CSR_MVENDORID:             rdata = '0;
            CSR_MIE:                   rdata = mie_q;
            CSR_MTVEC:                 rdata = mtvec_q;
            CSR_MSCRATCH:              rdata = mscratch_q;
            CSR_MEPC:                  rdata = mepc_q;
            CSR_MCAUSE:                rdata = mcause_q;
            CSR_MTVAL:                 rdata = mtval_q;
            CSR_MIP:                   rdata = mip_rd;
            CSR_MCYCLE, CSR_CYCLE:     rdata = mcycle[XLEN-1:0];
            CSR_MCYCLEH, CSR_CYCLEH:   rdata = XLEN'(mcycle[CNT_WIDTH-1:XLEN]);
            CSR_MINSTRET, CSR_INSTRET: rdata = minstret[XLEN-1:0];
            CSR_MINSTRETH, CSR_INSTRETH: rdata = XLEN'(minstret[CNT_WIDTH-1:XLEN]);
            default: begin
                hit = 1'b0;
                for (int i = 0; i < NUM_CUSTOM; i++) begin
                    if (bus.csr_addr == CSR_CUSTOM0 + 12'(i)) begin
                        hit   = 1'b1;
                        rdata = cust_q[i];
                    end
                end
            end
        endcase
    end

    // The 0x3xx misa is read-only despite its address bits, so it is listed explicitly.
    assign is_write        = bus.csr_w_en && (bus.csr_op != CSR_READ);
    assign illegal         = bus.csr_en && (!hit || (is_write &&
                             (bus.csr_addr[11:10] == 2'b11 || bus.csr_addr == CSR_MISA)));
    assign commit          = bus.csr_en && is_write && !illegal && !trap_req && !mret;
    assign wdata           = csr_wval(bus.csr_op, rdata, bus.csr_in);
    assign bus.csr_rdata   = bus.csr_en ? rdata : '0;
    assign bus.csr_illegal = illegal;

    always_comb begin
        trap_mcause           = XLEN'(trap_cause);
        trap_mcause[XLEN-1]   = trap_is_irq;
        vec_base              = mtvec_q & ~XLEN'(3);
        redirect_pc           = '0;
        if (trap_req) begin
            redirect_pc = vec_base + ((mtvec_q[1:0] == 2'b01 && trap_is_irq) ?
                                      XLEN'({trap_cause, 2'b00}) : '0);
        end else if (mret) begin
            redirect_pc = mepc_q;
        end
    end

    // External interrupt outranks software, which outranks timer.
    assign irq_act     = mip_q & {mie_q[IRQ_M_EXT], mie_q[IRQ_M_TIMER], mie_q[IRQ_M_SW]};
    assign irq_pending = mst_mie && (|irq_act);
    assign irq_code    = irq_act[2] ? IRQ_M_EXT :
                         irq_act[0] ? IRQ_M_SW  :
                         irq_act[1] ? IRQ_M_TIMER : 5'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mst_mpp    <= MPP_M;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
            for (int i = 0; i < NUM_CUSTOM; i++) cust_q[i] <= '0;
        end else begin
            mip_q <= {irq_ext, irq_timer, irq_sw};
            if (trap_req) begin
                mepc_q   <= trap_pc & ~XLEN'(3);
                mcause_q <= trap_mcause;
                mtval_q  <= trap_tval;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
                mst_mpp  <= MPP_M;
            end else if (mret) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
                mst_mpp  <= MPP_U;
            end else if (commit) begin
                case (bus.csr_addr)
                    CSR_MSTATUS: begin
                        mst_mie  <= wdata[MSTATUS_MIE];
                        mst_mpie <= wdata[MSTATUS_MPIE];
                        if (wdata[MSTATUS_MPP_LO +: 2] == MPP_M || wdata[MSTATUS_MPP_LO +: 2] == MPP_U)
                            mst_mpp <= wdata[MSTATUS_MPP_LO +: 2];
                    end
                    CSR_MIE:      mie_q      <= wdata & IRQ_MASK;
                    CSR_MTVEC:    mtvec_q    <= mtvec_legal(wdata);
                    CSR_MSCRATCH: mscratch_q <= wdata;
                    CSR_MEPC:     mepc_q     <= wdata & ~XLEN'(3);
                    CSR_MCAUSE:   mcause_q   <= wdata;
                    CSR_MTVAL:    mtval_q    <= wdata;
                    default: begin
                        for (int i = 0; i < NUM_CUSTOM; i++) begin
                            if (bus.csr_addr == CSR_CUSTOM0 + 12'(i)) cust_q[i] <= wdata;
                        end
                    end
                endcase
            end
        end
    end

    csr_file_trap_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (commit && bus.csr_addr == CSR_MCYCLE),
        .wr_hi (commit && bus.csr_addr == CSR_MCYCLEH),
        .wdata (wdata),
        .count (mcycle)
    );

    csr_file_trap_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .wr_lo (commit && bus.csr_addr == CSR_MINSTRET),
        .wr_hi (commit && bus.csr_addr == CSR_MINSTRETH),
        .wdata (wdata),
        .count (minstret)
    );
endmodule
